// File: rtl/parity_frame_pkg.sv
// Shared types and defaults for the parity framing scheduler.
// Holds the FSM state encoding plus default requester count and word width.
// FRAME_W is the default frame width: parity bit on top of the data word.
package parity_frame_pkg;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 7;
   localparam int FRAME_W  = DW_DEF + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      EMIT  = 2'd2
   } state_t;

endpackage

// File: rtl/parity_shift_unit.sv
// Serial shift/parity unit: collects bits MSB-first and keeps a running even parity.
// Latency: each bit is absorbed on the edge where shift_en=1; frame reflects it next cycle.
// No backpressure: the caller controls pacing through shift_en.
// Ports: clk, reset (sync, active-low), clear (sync wipe), shift_en, shift_in,
//        frame = {parity, collected word}.
module parity_shift_unit #(
   parameter int DW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          shift_en,
   input  logic          shift_in,
   output logic [DW:0]   frame
);

   logic [DW-1:0] word;
   logic          parity;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         word   <= '0;
         parity <= 1'b0;
      end else if (shift_en) begin
         word   <= {word[DW-2:0], shift_in};
         parity <= parity ^ shift_in;
      end
   end

   assign frame = {parity, word};

endmodule

// File: rtl/parity_frame_sched.sv
// Round-robin scheduler feeding one serial parity-framing unit from NREQ requesters.
// Latency: frame_valid in the DW+1th cycle after the accept edge; DW+2 cycles per frame minimum.
// Backpressure: frame held stable while frame_ready=0; no new grant until the frame is taken.
// Ports: clk, reset (sync, active-low); req_valid/req_data/req_ready per requester;
//        ser_en/ser_bit serial strobe; frame_valid/frame_data/frame_id/frame_ready; busy.
module parity_frame_sched
   import parity_frame_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   localparam int IDW = $clog2(NREQ),
   localparam int CW  = $clog2(DW)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 ser_en,
   output logic                 ser_bit,
   output logic                 frame_valid,
   output logic [DW:0]          frame_data,
   output logic [IDW-1:0]       frame_id,
   input  logic                 frame_ready,
   output logic                 busy
);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id_q;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   word_q;      // remaining bits, next one to send sits in the MSB
   logic            ser_bit_q;
   logic [DW:0]     unit_frame;

   logic            grant_any;
   logic [IDW-1:0]  grant_id;
   logic [DW-1:0]   sel_word;
   logic            accept;

   // Search ptr+1, ptr+2, ... so the last served requester has lowest priority.
   always_comb begin
      int             sum;
      logic [IDW-1:0] idx;
      grant_any = 1'b0;
      grant_id  = '0;
      sum       = 0;
      idx       = '0;
      for (int i = 1; i <= NREQ; i++) begin
         sum = int'(ptr) + i;
         if (sum >= NREQ) sum = sum - NREQ;
         idx = IDW'(sum);
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
   end

   // Grant is gated by reset so nothing is accepted while reset is held.
   assign accept    = reset && (state == IDLE) && grant_any;
   assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;
   assign sel_word  = req_data[grant_id*DW +: DW];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= IDW'(NREQ-1);
         id_q      <= '0;
         cnt       <= '0;
         word_q    <= '0;
         ser_bit_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  id_q      <= grant_id;
                  ser_bit_q <= sel_word[DW-1];
                  word_q    <= {sel_word[DW-2:0], 1'b0};
                  cnt       <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               ser_bit_q <= word_q[DW-1];
               word_q    <= {word_q[DW-2:0], 1'b0};
               cnt       <= cnt + 1'b1;
               if (cnt == CW'(DW-1)) begin
                  ser_bit_q <= 1'b0;
                  state     <= EMIT;
               end
            end
            EMIT: begin
               if (frame_ready) begin
                  ptr   <= id_q;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ser_en      = (state == SHIFT);
   assign ser_bit     = ser_en & ser_bit_q;
   assign frame_valid = (state == EMIT);
   assign frame_data  = frame_valid ? unit_frame : '0;
   assign frame_id    = frame_valid ? id_q : '0;
   assign busy        = (state != IDLE);

   // Clearing on accept discards whatever the previous frame left behind.
   parity_shift_unit #(.DW(DW)) u_shift (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .shift_en (ser_en),
      .shift_in (ser_bit),
      .frame    (unit_frame)
   );

endmodule

// File: tb/tb_parity_frame_sched.sv
module tb_parity_frame_sched;

   localparam int NREQ = 4;
   localparam int DW   = 7;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                ser_en;
   logic                ser_bit;
   logic                frame_valid;
   logic [DW:0]         frame_data;
   logic [1:0]          frame_id;
   logic                frame_ready;
   logic                busy;

   parity_frame_sched #(.NREQ(NREQ), .DW(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .ser_en      (ser_en),
      .ser_bit     (ser_bit),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_id    (frame_id),
      .frame_ready (frame_ready),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard state
   int          grant_q[$];
   logic [7:0]  fdata_q[$];
   int          fid_q[$];
   logic        bit_q[$];
   int          acc_log[$];
   int          cyc;
   int          acc_cyc;
   logic        prev_fv;
   logic [7:0]  last_data;
   logic [1:0]  last_id;

   // Monitor: samples on the falling edge, pushes expectations on accept, pops on output.
   initial begin
      int         g;
      logic [6:0] w;
      cyc = 0; acc_cyc = 0; prev_fv = 1'b0; last_data = '0; last_id = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            fdata_q.delete();
            fid_q.delete();
            bit_q.delete();
            prev_fv = 1'b0;
         end else begin
            if (ser_en) begin
               check("ser_bit_expected", int'(bit_q.size() != 0), 1);
               if (bit_q.size() != 0) check("ser_bit", ser_bit, bit_q.pop_front());
            end
            if (|req_ready) begin
               g = 0;
               for (int r = 0; r < NREQ; r++) if (req_ready[r]) g = r;
               check("grant_onehot", $countones(req_ready), 1);
               check("grant_valid", req_valid & req_ready, req_ready);
               check("grant_expected", int'(grant_q.size() != 0), 1);
               if (grant_q.size() != 0) check("grant_id", g, grant_q.pop_front());
               w = req_data[g*DW +: DW];
               fdata_q.push_back({^w, w});
               fid_q.push_back(g);
               for (int b = DW-1; b >= 0; b--) bit_q.push_back(w[b]);
               acc_cyc = cyc;
               acc_log.push_back(cyc);
            end
            if (frame_valid && !prev_fv) check("frame_latency", cyc - acc_cyc, DW+1);
            if (frame_valid) check("no_grant_in_emit", req_ready, 0);
            if (frame_valid && frame_ready) begin
               check("frame_expected", int'(fdata_q.size() != 0), 1);
               if (fdata_q.size() != 0) begin
                  check("frame_data", frame_data, fdata_q.pop_front());
                  check("frame_id", frame_id, fid_q.pop_front());
               end
               last_data = frame_data;
               last_id   = frame_id;
            end
            prev_fv = frame_valid;
         end
      end
   end

   task automatic send(input int r, input logic [6:0] w);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      req_data[r*DW +: DW] = w;
      req_valid[r] = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (reset && req_ready[r]) got = 1'b1;
      end
      check($sformatf("grant_timeout_r%0d", r), got, 1);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (!busy && fdata_q.size() == 0 && req_valid == '0) ok = 1'b1;
      end
      check("idle_timeout", ok, 1);
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_req_ready"}, req_ready, 0);
      check({pfx, "_ser_en"}, ser_en, 0);
      check({pfx, "_ser_bit"}, ser_bit, 0);
      check({pfx, "_frame_valid"}, frame_valid, 0);
      check({pfx, "_frame_data"}, frame_data, 0);
      check({pfx, "_frame_id"}, frame_id, 0);
      check({pfx, "_busy"}, busy, 0);
   endtask

   initial begin
      int         start;
      bit         seen;
      logic [7:0] hd;
      logic [1:0] hi;

      // Reset state, with a requester valid to show no grant leaks through reset
      reset = 1'b0; req_valid = 4'b0001; req_data = '0; frame_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b1; req_valid = '0;

      // 1: single word from requester 0
      grant_q.push_back(0);
      send(0, 7'b1010011);
      wait_idle();
      check("t1_frame_data", last_data, 8'h53);
      check("t1_frame_id", last_id, 0);

      // 2: parity patterns
      grant_q.push_back(1);
      send(1, 7'b0000111);
      wait_idle();
      check("t2_frame_07", last_data, 8'h87);
      grant_q.push_back(2);
      send(2, 7'h00);
      wait_idle();
      check("t2_frame_00", last_data, 8'h00);
      grant_q.push_back(3);
      send(3, 7'h7F);
      wait_idle();
      check("t2_frame_7f", last_data, 8'hFF);

      // 3: all requesters busy, round-robin order and spacing
      start = acc_log.size();
      grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
      grant_q.push_back(3); grant_q.push_back(0); grant_q.push_back(1);
      fork
         begin send(0, 7'(($urandom_range(0, 127)))); send(0, 7'h15); end
         begin send(1, 7'(($urandom_range(0, 127)))); send(1, 7'h6A); end
         send(2, 7'h33);
         send(3, 7'h4C);
      join
      wait_idle();
      check("t3_grant_count", acc_log.size() - start, 6);
      for (int i = 1; i < 6 && start + i < acc_log.size(); i++)
         check($sformatf("t3_spacing_%0d", i), acc_log[start+i] - acc_log[start+i-1], DW+2);

      // 4: downstream stall in EMIT with another requester waiting
      @(posedge clk); #1;
      frame_ready = 1'b0;
      grant_q.push_back(2); grant_q.push_back(3);
      fork
         send(2, 7'h5A);
         send(3, 7'h21);
         begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
               @(negedge clk);
               if (frame_valid) seen = 1'b1;
            end
            check("t4_emit_seen", seen, 1);
            hd = frame_data; hi = frame_id;
            repeat (5) begin
               @(negedge clk);
               check("t4_hold_valid", frame_valid, 1);
               check("t4_hold_data", frame_data, hd);
               check("t4_hold_id", frame_id, hi);
               check("t4_hold_no_ready", req_ready, 0);
            end
            @(posedge clk); #1;
            frame_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("t4_idle_after_hs", busy, 0);
            check("t4_next_grant", req_ready, 4'b1000);
         end
      join
      wait_idle();

      // 5: reset in the middle of SHIFT
      grant_q.push_back(0);
      send(0, 7'h6D);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("t5");
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("t5_no_frame", frame_valid, 0);
      grant_q.push_back(1); grant_q.push_back(3);
      fork
         send(1, 7'h19);
         send(3, 7'h62);
      join
      wait_idle();

      // 6: late requester 2 comes and goes while another frame is in flight
      grant_q.push_back(0);
      fork
         send(0, 7'h2A);
         begin
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
               @(negedge clk);
               if (ser_en) seen = 1'b1;
            end
            check("t6_shift_seen", seen, 1);
            @(posedge clk); #1;
            req_data[2*DW +: DW] = 7'h7E;
            req_valid[2] = 1'b1;
            repeat (3) @(posedge clk);
            #1 req_valid[2] = 1'b0;
         end
      join
      wait_idle();
      repeat (10) @(negedge clk);
      check("t6_last_id", last_id, 0);
      check("t6_grants_consumed", grant_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
